pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Merges four requests into one set of per-stage enable/flush controls:
  - load-use stall from hazard detection
  - taken-branch flush from ID
  - multi-cycle MUL/DIV occupancy of EXE
  - data-memory wait in MEM
- Sequences multi-cycle EXE ops with a latency counter.
- Watches MEM wait length with a watchdog.

Parameters:
- MUL_LAT, 3, total EXE cycles for a multiply (>=2)
- DIV_LAT, 33, total EXE cycles for a divide (>=2)
- CNT_W, 6, width of latency counter; must hold max(MUL_LAT,DIV_LAT)-2
- MEM_TIMEOUT, 255, consecutive MEM wait cycles before timeout flag (>=1)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hdu_stall  in  1  load-use stall request from hazard detection (ID)
- Branch_ID  in  1  taken branch/jump resolved in ID
- mc_start_EXE  in  1  valid MUL/DIV op currently in EXE
- mc_is_div  in  1  1=divide, 0=multiply; qualifies mc_start_EXE
- dmem_req_MEM  in  1  load/store in MEM requesting memory
- dmem_ack  in  1  memory completes request this cycle
- PC_EN_IF  out  1  PC update enable
- reg_FD_EN  out  1  IF/ID register enable
- reg_FD_flush  out  1  IF/ID bubble insert
- reg_DE_EN  out  1  ID/EX register enable
- reg_DE_flush  out  1  ID/EX bubble insert
- reg_EM_EN  out  1  EX/MEM register enable
- reg_EM_flush  out  1  EX/MEM bubble insert
- reg_MW_EN  out  1  MEM/WB register enable
- mc_busy  out  1  multi-cycle op holding EXE
- mc_done  out  1  1-cycle pulse: MUL/DIV result valid, EXE advances
- mem_timeout  out  1  sticky watchdog flag
- perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Sequential state:
  - FSM {RUN, MC_BUSY}
  - cnt[CNT_W-1:0]
  - wait_cnt (8+ bits, saturating)
  - mem_timeout flag
- Reset (rst_n low, async):
  - State: RUN, cnt=0, wait_cnt=0, mem_timeout=0, perf_stall_cnt=0.
  - Outputs while rst_n low: all *_EN=0, all *_flush=0, mc_busy=0, mc_done=0.
- mem_wait = dmem_req_MEM & ~dmem_ack.
- Control outputs are combinational from state, cnt and inputs, evaluated in fixed priority:
  1. mem_wait: all EN=0, all flush=0 (whole pipe frozen).
  2. mc_freeze = (RUN & mc_start_EXE) | (MC_BUSY & cnt!=0) | (MC_BUSY & cnt==0 & mem_wait):
     - PC_EN_IF=reg_FD_EN=reg_DE_EN=0
     - reg_EM_EN=1, reg_EM_flush=1, reg_MW_EN=1
     - FD/DE flush=0
  3. hdu_stall: PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1, other EN=1.
  4. Branch_ID: reg_FD_flush=1, all EN=1.
  5. Otherwise: all EN=1, flush=0.
- Suppression: Branch_ID is ignored whenever FD is frozen (rules 1-3). The branch stays in ID and is re-evaluated.
- FSM:
  - RUN, mc_start_EXE & ~mem_wait: go to MC_BUSY; cnt <= (mc_is_div ? DIV_LAT : MUL_LAT) - 2.
  - RUN, mc_start_EXE & mem_wait: stay in RUN, no load.
  - MC_BUSY, cnt!=0: cnt decrements every cycle, including during mem_wait.
  - MC_BUSY, cnt==0 & ~mem_wait: mc_done=1, no freeze (pipe advances), next state RUN.
  - MC_BUSY, cnt==0 & mem_wait: hold in MC_BUSY, mc_done=0.
  - mc_start_EXE is ignored in MC_BUSY.
- Resulting occupancy: a MUL holds EXE exactly MUL_LAT cycles (DIV_LAT for divide) when there is no mem wait. Back-to-back MC ops re-enter MC_BUSY the cycle after mc_done.
- mc_busy = (state==MC_BUSY) | (RUN & mc_start_EXE).
- Watchdog:
  - wait_cnt increments on mem_wait, clears when mem_wait=0, saturates at max.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout sets; cleared only by reset.
- Reset mid-op: an in-flight MUL/DIV is abandoned; no mc_done is issued.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: perf_stall_cnt is a 32-bit register incrementing each cycle with rst_n high and PC_EN_IF=0. It wraps 0xFFFFFFFF -> 0 and resets to 0.
- Undefined: no register; perf_stall_cnt tied to 32'h0.

Test Plan:
- Load-use: hdu_stall=1 for one cycle in RUN -> PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1 that cycle; next cycle all EN=1.
- Branch vs stall: Branch_ID=1 alone -> reg_FD_flush=1. Branch_ID=1 with hdu_stall=1 -> reg_FD_flush=0.
- MUL, MUL_LAT=3: mc_start_EXE=1, mc_is_div=0 at cycle t:
  - t, t+1: PC_EN_IF=0, reg_EM_flush=1.
  - t+2: mc_done=1, all EN=1.
  - DIV with DIV_LAT=33: mc_done at t+32.
- MEM wait inside MUL: dmem_req_MEM=1, dmem_ack=0 at t+1..t+4 -> all EN=0 those cycles; mc_done first at t+5; no double pulse.
- Watchdog, MEM_TIMEOUT=4: 4 consecutive wait cycles -> mem_timeout=1 and stays 1 after dmem_ack. Only rst_n low clears it.
- Reset during MC_BUSY (DIV, cnt=20): rst_n low -> state RUN, mc_busy=0, no mc_done. With STALL_PERF_CNT_EN, perf_stall_cnt=0, and it counts exactly the PC_EN_IF=0 cycles afterwards.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges load-use, branch, MUL/DIV and MEM-wait requests into per-stage enable/flush controls.
// Optional stall-cycle counter is built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int MUL_LAT     = 3,
    parameter int DIV_LAT     = 33,
    parameter int CNT_W       = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hdu_stall,
    input  logic        Branch_ID,
    input  logic        mc_start_EXE,
    input  logic        mc_is_div,
    input  logic        dmem_req_MEM,
    input  logic        dmem_ack,
    output logic        PC_EN_IF,
    output logic        reg_FD_EN,
    output logic        reg_FD_flush,
    output logic        reg_DE_EN,
    output logic        reg_DE_flush,
    output logic        reg_EM_EN,
    output logic        reg_EM_flush,
    output logic        reg_MW_EN,
    output logic        mc_busy,
    output logic        mc_done,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cnt
);
    localparam int WC_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    typedef enum logic {RUN, MC_BUSY} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              tmo_q, tmo_d;
    logic              mem_wait, in_run, cnt_zero, mc_freeze;
    // priority-encoded stage controls, next-state and watchdog logic
    always_comb begin
        mem_wait  = dmem_req_MEM & ~dmem_ack;
        in_run    = state_q == RUN;
        cnt_zero  = cnt_q == '0;
        mc_freeze = (in_run & mc_start_EXE) | (!in_run & (!cnt_zero | mem_wait));
        {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN} = 5'b11111;
        {reg_FD_flush, reg_DE_flush, reg_EM_flush} = 3'b000;
        if (!rst_n || mem_wait)
            {PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN} = 5'b00000;
        else if (mc_freeze) begin
            {PC_EN_IF, reg_FD_EN, reg_DE_EN} = 3'b000;
            reg_EM_flush = 1'b1;
        end else if (hdu_stall) begin
            {PC_EN_IF, reg_FD_EN} = 2'b00;
            reg_DE_flush = 1'b1;
        end else if (Branch_ID)
            reg_FD_flush = 1'b1;
        mc_busy     = rst_n & (!in_run | mc_start_EXE);
        mc_done     = rst_n & !in_run & cnt_zero & !mem_wait;
        mem_timeout = tmo_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_run) begin
            if (mc_start_EXE && !mem_wait) begin
                state_d = MC_BUSY;
                cnt_d   = mc_is_div ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
            end
        end else if (!cnt_zero)
            cnt_d = cnt_q - 1'b1;
        else if (!mem_wait)
            state_d = RUN;
        wait_d = !mem_wait ? '0 : (&wait_q ? wait_q : wait_q + 1'b1);
        tmo_d  = tmo_q | (mem_wait & (wait_q >= WC_W'(MEM_TIMEOUT - 1)));
    end
    // state, latency counter and watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_q;
    // counts every cycle the PC is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_q <= '0;
        else if (!PC_EN_IF)
            perf_q <= perf_q + 1'b1;
    end
    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed-vector bench for pipe_stall_ctrl (MUL_LAT=3, DIV_LAT=33, MEM_TIMEOUT=4).
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hdu_stall = 0, Branch_ID = 0, mc_start_EXE = 0, mc_is_div = 0, dmem_req_MEM = 0, dmem_ack = 0;
    logic PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN;
    logic mc_busy, mc_done, mem_timeout;
    logic [31:0] perf_stall_cnt;
    int checks = 0;
    int failures = 0;

    // ctrl order: PC FD_EN FD_fl DE_EN DE_fl EM_EN EM_fl MW busy done
    localparam logic [9:0] C_RST   = 10'b0000000000;
    localparam logic [9:0] C_IDLE  = 10'b1101010100;
    localparam logic [9:0] C_HDU   = 10'b0001110100;
    localparam logic [9:0] C_BR    = 10'b1111010100;
    localparam logic [9:0] C_FRZ   = 10'b0000011110;
    localparam logic [9:0] C_DONE  = 10'b1101010111;
    localparam logic [9:0] C_MWAIT = 10'b0000000010;

    pipe_stall_ctrl #(.MUL_LAT(3), .DIV_LAT(33), .CNT_W(6), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .hdu_stall(hdu_stall), .Branch_ID(Branch_ID),
        .mc_start_EXE(mc_start_EXE), .mc_is_div(mc_is_div), .dmem_req_MEM(dmem_req_MEM),
        .dmem_ack(dmem_ack), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
        .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush), .reg_EM_EN(reg_EM_EN),
        .reg_EM_flush(reg_EM_flush), .reg_MW_EN(reg_MW_EN), .mc_busy(mc_busy), .mc_done(mc_done),
        .mem_timeout(mem_timeout), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl();
        return {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush,
                reg_EM_EN, reg_EM_flush, reg_MW_EN, mc_busy, mc_done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic br, input logic ms, input logic dv, input logic rq, input logic ak);
        {hdu_stall, Branch_ID, mc_start_EXE, mc_is_div, dmem_req_MEM, dmem_ack} = {hs, br, ms, dv, rq, ak};
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_ctrl", 32'(ctrl()), 32'(C_RST));
        chk("rst_tmo", 32'(mem_timeout), 32'd0);
        chk("rst_perf", perf_stall_cnt, 32'd0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("idle", 32'(ctrl()), 32'(C_IDLE));
        drive(1, 0, 0, 0, 0, 0);
        chk("load_use", 32'(ctrl()), 32'(C_HDU));
        step();
`ifdef STALL_PERF_CNT_EN
        chk("perf_one", perf_stall_cnt, 32'd1);
`else
        chk("perf_tied", perf_stall_cnt, 32'd0);
`endif
        drive(0, 0, 0, 0, 0, 0);
        chk("after_stall", 32'(ctrl()), 32'(C_IDLE));
        drive(0, 1, 0, 0, 0, 0);
        chk("branch", 32'(ctrl()), 32'(C_BR));
        drive(1, 1, 0, 0, 0, 0);
        chk("branch_vs_stall", 32'(ctrl()), 32'(C_HDU));
        step();
        // MUL: freeze t, t+1; done at t+2
        drive(0, 1, 1, 0, 0, 0);
        chk("mul_t0", 32'(ctrl()), 32'(C_FRZ));
        step();
        chk("mul_t1", 32'(ctrl()), 32'(C_FRZ));
        step();
        chk("mul_t2_done", 32'(ctrl()), 32'(C_DONE & ~10'b0010000000 | 10'b0010000000));
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("mul_after", 32'(ctrl()), 32'(C_IDLE));
        // DIV: done first at t+32
        drive(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("div_frz_%0d", i), 32'(ctrl()), 32'(C_FRZ));
            step();
        end
        chk("div_done", 32'(ctrl()), 32'(C_DONE));
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("div_after", 32'(ctrl()), 32'(C_IDLE));
        // MUL with MEM wait t+1..t+4; watchdog trips after 4 waits
        drive(0, 0, 1, 0, 0, 0);
        chk("mw_t0", 32'(ctrl()), 32'(C_FRZ));
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 0, 1, 0);
            chk($sformatf("mw_wait_%0d", i), 32'(ctrl()), 32'(C_MWAIT));
            chk($sformatf("mw_tmo_%0d", i), 32'(mem_timeout), 32'd0);
            step();
        end
        drive(0, 0, 1, 0, 1, 1);
        chk("mw_done", 32'(ctrl()), 32'(C_DONE));
        chk("tmo_set", 32'(mem_timeout), 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("mw_no_double", 32'(mc_done), 32'd0);
        step();
        chk("tmo_sticky", 32'(mem_timeout), 32'd1);
        // reset in the middle of a divide (cnt=20)
        drive(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step();
        chk("div_mid_busy", 32'(ctrl()), 32'(C_FRZ));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'(ctrl()), 32'(C_RST));
        chk("mid_rst_tmo", 32'(mem_timeout), 32'd0);
        chk("mid_rst_perf", perf_stall_cnt, 32'd0);
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            chk($sformatf("post_rst_%0d", i), 32'(ctrl()), 32'(C_IDLE));
            step();
        end
        drive(1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
`ifdef STALL_PERF_CNT_EN
        chk("post_rst_perf", perf_stall_cnt, 32'd1);
`else
        chk("post_rst_perf", perf_stall_cnt, 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
